// File: rtl/rx_credit_scheduler.sv
// SpaceWire receive-side flow-control credit scheduler: tracks RX FIFO occupancy and
// outstanding credit, and requests an FCT whenever the FIFO can absorb another grant.
module rx_credit_scheduler #(
    parameter int FIFO_DEPTH = 56,
    parameter int CREDIT_MAX = 56,
    parameter int FCT_GRANT  = 8,
    parameter int CWIDTH     = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              link_en,
    input  logic              rx_char_stored,
    input  logic              rx_char_read,
    input  logic              fct_ack,
    output logic              fct_req,
    output logic [CWIDTH-1:0] credit,
    output logic [CWIDTH-1:0] occupancy,
    output logic              credit_error
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        REQ   = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [CWIDTH-1:0] GRANT       = CWIDTH'(FCT_GRANT);
    localparam logic [CWIDTH-1:0] GRANT_M1    = CWIDTH'(FCT_GRANT - 1);
    localparam logic [CWIDTH-1:0] DEPTH       = CWIDTH'(FIFO_DEPTH);
    localparam logic [CWIDTH:0]   GRANT_W     = (CWIDTH+1)'(FCT_GRANT);
    localparam logic [CWIDTH:0]   DEPTH_W     = (CWIDTH+1)'(FIFO_DEPTH);
    localparam logic [CWIDTH:0]   CREDIT_MAXW = (CWIDTH+1)'(CREDIT_MAX);

    state_t            state, state_nxt;
    logic              fct_req_nxt;
    logic [CWIDTH-1:0] credit_nxt, occupancy_nxt;
    logic              credit_error_nxt;
    logic              ack_take;
    logic              eligible;
    logic [CWIDTH:0]   fill_sum, credit_sum;

    // Sums are one bit wider than the counters so the comparisons cannot wrap.
    assign fill_sum   = {1'b0, occupancy} + {1'b0, credit} + GRANT_W;
    assign credit_sum = {1'b0, credit} + GRANT_W;
    assign eligible   = (fill_sum <= DEPTH_W) && (credit_sum <= CREDIT_MAXW);
    assign ack_take   = (state == REQ) && fct_ack;

    // NOTE: every signal assigned in an always_comb gets a default first, otherwise
    // paths that skip an assignment would infer a latch.
    always_comb begin
        state_nxt   = state;
        fct_req_nxt = fct_req;
        unique case (state)
            IDLE: begin
                fct_req_nxt = 1'b0;
                if (link_en) state_nxt = CHECK;
            end
            CHECK: begin
                if (eligible) begin
                    state_nxt   = REQ;
                    fct_req_nxt = 1'b1;
                end
            end
            REQ: begin
                if (fct_ack) begin
                    state_nxt   = HOLD;
                    fct_req_nxt = 1'b0;
                end
            end
            HOLD: state_nxt = CHECK;
            default: begin
                state_nxt   = IDLE;
                fct_req_nxt = 1'b0;
            end
        endcase
        if (!link_en) begin
            state_nxt   = IDLE;
            fct_req_nxt = 1'b0;
        end
    end

    always_comb begin
        credit_nxt       = credit;
        occupancy_nxt    = occupancy;
        credit_error_nxt = credit_error;

        // A grant arriving together with a stored N-char covers it, so no error.
        if (ack_take && rx_char_stored) begin
            credit_nxt = credit + GRANT_M1;
        end else if (ack_take) begin
            credit_nxt = credit + GRANT;
        end else if (rx_char_stored) begin
            if (credit != '0) credit_nxt = credit - 1'b1;
            else              credit_error_nxt = 1'b1;
        end

        unique case ({rx_char_stored, rx_char_read})
            2'b10:   if (occupancy != DEPTH) occupancy_nxt = occupancy + 1'b1;
            2'b01:   if (occupancy != '0)    occupancy_nxt = occupancy - 1'b1;
            default: occupancy_nxt = occupancy;
        endcase

        if (!link_en) begin
            credit_nxt       = '0;
            occupancy_nxt    = '0;
            credit_error_nxt = 1'b0;
        end
    end

    // NOTE: sequential state is updated only with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            fct_req      <= 1'b0;
            credit       <= '0;
            occupancy    <= '0;
            credit_error <= 1'b0;
        end else begin
            state        <= state_nxt;
            fct_req      <= fct_req_nxt;
            credit       <= credit_nxt;
            occupancy    <= occupancy_nxt;
            credit_error <= credit_error_nxt;
        end
    end

endmodule

// File: tb/tb_rx_credit_scheduler.sv
// Self-checking bench for rx_credit_scheduler: directed scenarios plus randomized
// traffic compared cycle by cycle against a behavioural credit/occupancy model.
module tb_rx_credit_scheduler;

    localparam int FIFO_DEPTH = 56;
    localparam int CREDIT_MAX = 56;
    localparam int FCT_GRANT  = 8;
    localparam int CWIDTH     = 6;

    logic              clock = 1'b0;
    logic              reset;
    logic              link_en;
    logic              rx_char_stored;
    logic              rx_char_read;
    logic              fct_ack;
    logic              fct_req;
    logic [CWIDTH-1:0] credit;
    logic [CWIDTH-1:0] occupancy;
    logic              credit_error;

    int checks = 0;
    int errors = 0;

    // Behavioural model: counters as plain integers, request pacing as a
    // "link up" flag, a pending-request flag and a cooldown count.
    int m_credit, m_occ, m_cool;
    bit m_err, m_req, m_up;

    rx_credit_scheduler #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .CREDIT_MAX(CREDIT_MAX),
        .FCT_GRANT (FCT_GRANT),
        .CWIDTH    (CWIDTH)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .link_en       (link_en),
        .rx_char_stored(rx_char_stored),
        .rx_char_read  (rx_char_read),
        .fct_ack       (fct_ack),
        .fct_req       (fct_req),
        .credit        (credit),
        .occupancy     (occupancy),
        .credit_error  (credit_error)
    );

    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_clear();
        m_credit = 0; m_occ = 0; m_cool = 0;
        m_err = 0; m_req = 0; m_up = 0;
    endtask

    task automatic model_step();
        bit take, elig;
        int cr, oc;
        if (!reset || !link_en) begin
            model_clear();
            return;
        end
        cr   = m_credit;
        oc   = m_occ;
        take = m_req && fct_ack;
        elig = (oc + cr + FCT_GRANT <= FIFO_DEPTH) && (cr + FCT_GRANT <= CREDIT_MAX);

        if (take)                m_credit = cr + FCT_GRANT - (rx_char_stored ? 1 : 0);
        else if (rx_char_stored) begin
            if (cr > 0) m_credit = cr - 1;
            else        m_err = 1;
        end

        if (rx_char_stored && !rx_char_read)      m_occ = (oc < FIFO_DEPTH) ? oc + 1 : oc;
        else if (rx_char_read && !rx_char_stored) m_occ = (oc > 0) ? oc - 1 : 0;

        if (!m_up)           m_up = 1;
        else if (m_req)      begin if (fct_ack) begin m_req = 0; m_cool = 1; end end
        else if (m_cool > 0) m_cool--;
        else if (elig)       m_req = 1;
    endtask

    // Advance one clock: the model sees the same inputs the DUT samples, then
    // outputs are observed 1 time unit after the edge.
    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic wait_req(input int budget, input string name);
        int n = 0;
        while (!fct_req && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (fct_req !== 1'b1) begin
            errors++;
            $display("FAIL %s: fct_req never rose within %0d cycles", name, budget);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; link_en = 1'b0; rx_char_stored = 1'b0;
        rx_char_read = 1'b0; fct_ack = 1'b0;
        model_clear();
        repeat (5) tick();
        checks++;
        if ({fct_req, credit, occupancy, credit_error} !== '0) begin
            errors++;
            $display("FAIL reset: req=%b credit=%0d occ=%0d err=%b, want all 0",
                     fct_req, credit, occupancy, credit_error);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_startup();
        int nfct = 0;
        bit late_req = 0;
        link_en = 1'b1;
        for (int i = 0; i < 100; i++) begin
            fct_ack = fct_req;
            tick();
            if (fct_ack) nfct++;
        end
        fct_ack = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (fct_req) late_req = 1;
        end
        checks++;
        if (nfct != 7) begin
            errors++;
            $display("FAIL startup_count: got %0d FCTs, want 7", nfct);
        end
        checks++;
        if (credit !== 6'd56 || occupancy !== 6'd0) begin
            errors++;
            $display("FAIL startup_counters: credit=%0d occ=%0d, want 56/0", credit, occupancy);
        end
        checks++;
        if (late_req) begin
            errors++;
            $display("FAIL startup_idle: fct_req=1 seen with full credit, want 0");
        end
    endtask

    task automatic test_fill();
        bit saw_req = 0;
        for (int i = 0; i < 8; i++) begin
            rx_char_stored = 1'b1; tick();
            rx_char_stored = 1'b0; tick();
            if (fct_req) saw_req = 1;
        end
        checks++;
        if (credit !== 6'd48 || occupancy !== 6'd8 || saw_req) begin
            errors++;
            $display("FAIL fill: credit=%0d occ=%0d req_seen=%b, want 48/8/0",
                     credit, occupancy, saw_req);
        end
    endtask

    task automatic test_drain();
        bit late_req = 0;
        for (int i = 0; i < 8; i++) begin
            rx_char_read = 1'b1; tick();
            rx_char_read = 1'b0;
        end
        checks++;
        if (occupancy !== 6'd0) begin
            errors++;
            $display("FAIL drain_occ: occ=%0d, want 0", occupancy);
        end
        wait_req(10, "drain_req");
        fct_ack = 1'b1; tick(); fct_ack = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (fct_req) late_req = 1;
        end
        checks++;
        if (credit !== 6'd56 || late_req) begin
            errors++;
            $display("FAIL drain_regrant: credit=%0d extra_req=%b, want 56/0", credit, late_req);
        end
    endtask

    task automatic test_credit_error();
        link_en = 1'b0; tick();
        link_en = 1'b1; tick();
        rx_char_stored = 1'b1; tick(); rx_char_stored = 1'b0;
        checks++;
        if (credit_error !== 1'b1 || credit !== 6'd0 || occupancy !== 6'd1) begin
            errors++;
            $display("FAIL credit_error: err=%b credit=%0d occ=%0d, want 1/0/1",
                     credit_error, credit, occupancy);
        end
        tick(); tick();
        checks++;
        if (credit_error !== 1'b1) begin
            errors++;
            $display("FAIL credit_error_sticky: err=%b, want 1", credit_error);
        end
        link_en = 1'b0; tick();
        checks++;
        if ({fct_req, credit, occupancy, credit_error} !== '0) begin
            errors++;
            $display("FAIL link_clear: req=%b credit=%0d occ=%0d err=%b, want all 0",
                     fct_req, credit, occupancy, credit_error);
        end
    endtask

    task automatic test_simultaneous();
        int nack = 0;
        link_en = 1'b1;
        for (int i = 0; i < 100 && nack < 6; i++) begin
            fct_ack = fct_req;
            tick();
            if (fct_ack) nack++;
        end
        fct_ack = 1'b0;
        wait_req(10, "simul_req");
        checks++;
        if (credit !== 6'd48) begin
            errors++;
            $display("FAIL simul_pre: credit=%0d, want 48", credit);
        end
        fct_ack = 1'b1; rx_char_stored = 1'b1; tick();
        fct_ack = 1'b0; rx_char_stored = 1'b0;
        checks++;
        if (credit !== 6'd55 || occupancy !== 6'd1 || fct_req !== 1'b0 || credit_error !== 1'b0) begin
            errors++;
            $display("FAIL ack_and_store: credit=%0d occ=%0d req=%b err=%b, want 55/1/0/0",
                     credit, occupancy, fct_req, credit_error);
        end
        repeat (3) begin
            rx_char_stored = 1'b1; tick(); rx_char_stored = 1'b0;
        end
        rx_char_stored = 1'b1; rx_char_read = 1'b1; tick();
        rx_char_stored = 1'b0; rx_char_read = 1'b0;
        checks++;
        if (occupancy !== 6'd4 || credit !== 6'd51) begin
            errors++;
            $display("FAIL store_and_read: occ=%0d credit=%0d, want 4/51", occupancy, credit);
        end
        fct_ack = 1'b1; tick(); tick(); fct_ack = 1'b0;
        checks++;
        if (credit !== 6'd51) begin
            errors++;
            $display("FAIL stray_ack: credit=%0d, want 51", credit);
        end
    endtask

    task automatic test_abort();
        link_en = 1'b0; tick();
        link_en = 1'b1;
        wait_req(10, "abort_req1");
        link_en = 1'b0; tick();
        checks++;
        if (fct_req !== 1'b0 || credit !== 6'd0) begin
            errors++;
            $display("FAIL link_abort: req=%b credit=%0d, want 0/0", fct_req, credit);
        end
        link_en = 1'b1;
        wait_req(10, "abort_req2");
        fct_ack = 1'b1; tick(); fct_ack = 1'b0;
        rx_char_stored = 1'b1; tick(); rx_char_stored = 1'b0;
        wait_req(10, "abort_req3");
        #2;
        reset = 1'b0;
        model_clear();
        #1;
        checks++;
        if ({fct_req, credit, occupancy, credit_error} !== '0) begin
            errors++;
            $display("FAIL async_reset: req=%b credit=%0d occ=%0d err=%b, want all 0",
                     fct_req, credit, occupancy, credit_error);
        end
        link_en = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_random();
        int shown = 0;
        for (int i = 0; i < 3000; i++) begin
            link_en        = ($urandom_range(0, 249) != 0);
            rx_char_stored = ($urandom_range(0, 2) == 0);
            rx_char_read   = ($urandom_range(0, 2) == 0);
            fct_ack        = ($urandom_range(0, 1) == 0);
            tick();
            checks++;
            if (fct_req !== m_req || int'(credit) != m_credit ||
                int'(occupancy) != m_occ || credit_error !== m_err) begin
                errors++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL random cycle %0d: req=%b credit=%0d occ=%0d err=%b, want %b/%0d/%0d/%b",
                             i, fct_req, credit, occupancy, credit_error,
                             m_req, m_credit, m_occ, m_err);
                end
            end
        end
        rx_char_stored = 1'b0; rx_char_read = 1'b0; fct_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_startup();
        test_fill();
        test_drain();
        test_credit_error();
        test_simultaneous();
        test_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_credit_scheduler.md
# rx_credit_scheduler

Flow-control credit scheduler for the SpaceWire receive path. Tracks RX FIFO occupancy and outstanding receive credit (N-chars the far end may still send), and requests FCT transmissions from the transmitter whenever the FIFO can absorb another 8 N-chars. Sits between the RX FIFO (stored/read strobes) and the TX FCT request input, and raises a credit error on the first N-char received with zero credit.

## Interface
- FIFO_DEPTH, 56, usable RX FIFO slots
- CREDIT_MAX, 56, maximum outstanding credit (7 FCTs)
- FCT_GRANT, 8, N-chars granted per FCT
- CWIDTH, 6, counter width. Constraint: FCT_GRANT <= CREDIT_MAX <= FIFO_DEPTH <= 2**CWIDTH-1.
- clock  in  1  system clock, all logic on posedge
- reset  in  1  asynchronous, active-low; clears all state
- link_en  in  1  link in Run/Started state; low = synchronous clear
- rx_char_stored  in  1  one-cycle pulse per N-char written into RX FIFO
- rx_char_read  in  1  one-cycle pulse per N-char consumed from RX FIFO
- fct_ack  in  1  TX accepted the pending FCT (meaningful only while fct_req=1)
- fct_req  out  1  registered FCT request, level, held until acked
- credit  out  CWIDTH  outstanding credit, 0..CREDIT_MAX
- occupancy  out  CWIDTH  N-chars in RX FIFO, 0..FIFO_DEPTH
- credit_error  out  1  sticky: N-char stored while credit==0

## Operation
- FSM states: IDLE, CHECK, REQ, HOLD. Reset state IDLE.
- IDLE: fct_req=0; go to CHECK when link_en=1.
- CHECK: eligible = (occupancy + credit + FCT_GRANT <= FIFO_DEPTH) and (credit + FCT_GRANT <= CREDIT_MAX), computed at CWIDTH+1 bits. Eligible -> REQ with fct_req=1; else stay CHECK.
- REQ: hold fct_req=1 until fct_ack=1; on ack credit += FCT_GRANT, fct_req=0, go HOLD.
- HOLD: one cycle, go CHECK.
- Any state: link_en=0 -> IDLE next edge, fct_req=0, credit=0, occupancy=0, credit_error=0.
- rx_char_stored: occupancy +1 (saturate FIFO_DEPTH); credit -1 if credit>0. If credit==0: credit stays 0, credit_error=1 (sticky until link_en=0 or reset).
- rx_char_read: occupancy -1; ignored when occupancy==0.
- Simultaneous stored+read: occupancy unchanged. Simultaneous ack+stored: credit += FCT_GRANT-1 (net +7). Ack+stored at credit==0: credit = FCT_GRANT-1, no credit_error (ack wins).
- fct_ack outside REQ: ignored, no counter change.

## Timing
- Reset values: fct_req=0, credit=0, occupancy=0, credit_error=0, state IDLE.
- link_en sampled high at edge N: CHECK at N; fct_req=1 after edge N+1 if eligible.
- fct_ack sampled at edge M: credit updated and fct_req=0 after M; earliest next fct_req=1 after M+2 (3-cycle FCT spacing).
- Counters and credit_error update on the edge sampling the strobe; visible next cycle.
- Eligibility uses registered counter values of the current cycle; a read in the same CHECK cycle is counted from the following cycle.
- Async reset mid-handshake: fct_req drops immediately, all outputs to reset values.

## Test plan
- Startup: reset low 5 cycles -> all outputs 0; link_en=1, ack each req 1 cycle after assertion -> exactly 7 FCTs, credit=56, occupancy=0, fct_req stays 0 afterwards.
- Fill: after startup, 8 stored pulses -> credit=48, occupancy=8, no fct_req (8+48+8>56).
- Drain: then 8 read pulses -> occupancy=0, one fct_req, ack -> credit=56, no further req.
- Credit error: link_en=1, fct_ack held 0, one stored pulse -> credit_error=1, credit=0, occupancy=1; link_en=0 -> all cleared.
- Simultaneous: credit=48 in REQ, ack and stored same cycle -> credit=55; stored+read same cycle at occupancy=4 -> occupancy=4, credit -1.
- Abort: link_en dropped while fct_req=1 -> fct_req=0 next cycle, credit=0; reset asserted mid-REQ -> outputs 0 without clock edge.
